fft_agu: RTL and testbench

- Address-generation and sequencing stage for the in-place radix-2 DIT FFT datapath.
- Drives both read and both write ports of the pipeline's dual-port working RAM (asynchronous read, synchronous write).
- Emits the twiddle index to the butterfly and delays write addresses/enables to match the butterfly pipeline latency.
- Sits directly upstream of the RAM's address/enable inputs; the butterfly sits between the RAM read data and write data.

---
 rtl/fft_agu.sv | 173 +++++++++++++++++
 tb/tb_fft_agu.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_agu.sv
// fft_agu -- address generator and sequencer for an in-place radix-2 DIT FFT.
//
// Walks L = ADDR_SIZE stages of N/2 butterflies each. One butterfly is issued
// per READ cycle. Each stage ends with BFLY_LAT DRAIN cycles so that the last
// write of a stage lands in RAM before the next stage reads it. The write
// addresses and enables are the issued read values delayed by BFLY_LAT cycles,
// which matches the butterfly pipeline between RAM read data and write data.
//
// Ports:
//   i_CLK                          clock, rising edge
//   i_RST                          synchronous active-low reset
//   i_start                        one-cycle request to run a transform (IDLE only)
//   o_busy                         high in READ and DRAIN
//   o_done                         one-cycle pulse after the final DRAIN cycle
//   o_stage                        current stage s
//   o_read_en_A/B, o_read_addr_A/B butterfly operand reads (addresses hold in DRAIN)
//   o_twiddle_addr                 twiddle ROM index, aligned with the read addresses
//   o_write_en_A/B, o_write_addr_A/B  read side delayed by BFLY_LAT cycles
module fft_agu #(
    parameter int MEM_SIZE  = 32,
    parameter int ADDR_SIZE = $clog2(MEM_SIZE),
    parameter int BFLY_LAT  = 2,
    parameter int STAGE_W   = $clog2(ADDR_SIZE + 1)
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [STAGE_W-1:0]   o_stage,
    output logic                 o_read_en_A,
    output logic                 o_read_en_B,
    output logic [ADDR_SIZE-1:0] o_read_addr_A,
    output logic [ADDR_SIZE-1:0] o_read_addr_B,
    output logic [ADDR_SIZE-2:0] o_twiddle_addr,
    output logic                 o_write_en_A,
    output logic                 o_write_en_B,
    output logic [ADDR_SIZE-1:0] o_write_addr_A,
    output logic [ADDR_SIZE-1:0] o_write_addr_B
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int KW = ADDR_SIZE - 1;           // butterfly index width (0..N/2-1)
    localparam int CW = $clog2(BFLY_LAT + 1);    // drain counter width
    localparam int DW = 2 * ADDR_SIZE + 1;       // {enable, addr_A, addr_B}

    localparam logic [KW-1:0]      K_LAST   = {KW{1'b1}};
    localparam logic [CW-1:0]      CNT_LAST = CW'(BFLY_LAT - 1);
    localparam logic [STAGE_W-1:0] S_LAST   = STAGE_W'(ADDR_SIZE - 1);

    logic [1:0]           state_q, state_d;
    logic [STAGE_W-1:0]   s_q, s_d;
    logic [KW-1:0]        k_q, k_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 re_q;
    logic [ADDR_SIZE-1:0] ra_q, rb_q;
    logic [KW-1:0]        tw_q;
    logic                 busy_q, done_q;
    logic [DW-1:0]        dl_q [BFLY_LAT];

    // Sequencer next state.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_READ;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            ST_READ: begin
                if (k_q == K_LAST) begin
                    state_d = ST_DRAIN;
                    k_d     = '0;
                    cnt_d   = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    if (s_q == S_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        s_d     = s_q + STAGE_W'(1);
                        state_d = ST_READ;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Addresses are derived from the next (s, k) so the registered outputs
    // line up with the state they belong to. At s = L-1 the KW-bit shift
    // wraps to zero and the subtraction yields an all-ones mask, as needed.
    logic [KW-1:0]        low_d;
    logic [ADDR_SIZE-1:0] a_d, b_d;
    logic [KW-1:0]        tw_d;

    assign low_d = k_d & ((KW'(1) << s_d) - KW'(1));
    assign a_d   = (({1'b0, k_d} >> s_d) << (s_d + STAGE_W'(1))) | {1'b0, low_d};
    assign b_d   = a_d | (ADDR_SIZE'(1) << s_d);
    assign tw_d  = low_d << (S_LAST - s_d);

    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            re_q    <= 1'b0;
            ra_q    <= '0;
            rb_q    <= '0;
            tw_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            re_q    <= (state_d == ST_READ);
            // Read addresses and twiddle hold their last value outside READ.
            if (state_d == ST_READ) begin
                ra_q <= a_d;
                rb_q <= b_d;
                tw_q <= tw_d;
            end
            busy_q  <= (state_d == ST_READ) || (state_d == ST_DRAIN);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Write-side delay line: element gi holds the read side from gi+1 cycles ago.
    for (genvar gi = 0; gi < BFLY_LAT; gi++) begin : g_dly
        if (gi == 0) begin : g_head
            always_ff @(posedge i_CLK) begin
                if (!i_RST) dl_q[gi] <= '0;
                else        dl_q[gi] <= {re_q, ra_q, rb_q};
            end
        end else begin : g_tail
            always_ff @(posedge i_CLK) begin
                if (!i_RST) dl_q[gi] <= '0;
                else        dl_q[gi] <= dl_q[gi-1];
            end
        end
    end

    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_stage        = s_q;
    assign o_read_en_A    = re_q;
    assign o_read_en_B    = re_q;
    assign o_read_addr_A  = ra_q;
    assign o_read_addr_B  = rb_q;
    assign o_twiddle_addr = tw_q;
    assign o_write_en_A   = dl_q[BFLY_LAT-1][DW-1];
    assign o_write_en_B   = dl_q[BFLY_LAT-1][DW-1];
    assign o_write_addr_A = dl_q[BFLY_LAT-1][DW-2 -: ADDR_SIZE];
    assign o_write_addr_B = dl_q[BFLY_LAT-1][ADDR_SIZE-1:0];

endmodule

// File: tb/tb_fft_agu.sv
module tb_fft_agu;
    localparam int N     = 32;
    localparam int L     = 5;
    localparam int BL    = 2;
    localparam int AW    = 5;
    localparam int SW    = 3;
    localparam int SPS   = N / 2 + BL;     // cycles per stage
    localparam int TOTAL = L * SPS + 1;    // run cycles including DONE

    logic clk;
    logic i_RST, i_start;
    logic o_busy, o_done;
    logic [SW-1:0] o_stage;
    logic o_read_en_A, o_read_en_B, o_write_en_A, o_write_en_B;
    logic [AW-1:0] o_read_addr_A, o_read_addr_B, o_write_addr_A, o_write_addr_B;
    logic [AW-2:0] o_twiddle_addr;

    fft_agu #(.MEM_SIZE(N), .BFLY_LAT(BL)) dut (
        .i_CLK(clk), .i_RST(i_RST), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_stage(o_stage),
        .o_read_en_A(o_read_en_A), .o_read_en_B(o_read_en_B),
        .o_read_addr_A(o_read_addr_A), .o_read_addr_B(o_read_addr_B),
        .o_twiddle_addr(o_twiddle_addr),
        .o_write_en_A(o_write_en_A), .o_write_en_B(o_write_en_B),
        .o_write_addr_A(o_write_addr_A), .o_write_addr_B(o_write_addr_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Expected per-cycle behaviour of one run, index 0 = first READ cycle.
    int e_re[TOTAL], e_a[TOTAL], e_b[TOTAL], e_tw[TOTAL], e_st[TOTAL];
    int e_we[TOTAL], e_wa[TOTAL], e_wb[TOTAL];

    task automatic build_model();
        for (int j = 0; j < TOTAL; j++) begin
            e_re[j] = 0; e_a[j] = 0; e_b[j] = 0; e_tw[j] = 0;
            if (j == TOTAL - 1) begin
                e_st[j] = L - 1;
            end else begin
                int st, r, span;
                st = j / SPS;
                r  = j % SPS;
                e_st[j] = st;
                if (r < N / 2) begin
                    span    = 1 << st;
                    e_re[j] = 1;
                    e_a[j]  = (r / span) * 2 * span + (r % span);
                    e_b[j]  = e_a[j] + span;
                    e_tw[j] = (r % span) * (N / (2 * span));
                end
            end
        end
        for (int j = 0; j < TOTAL; j++) begin
            e_we[j] = 0; e_wa[j] = 0; e_wb[j] = 0;
            if (j >= BL && e_re[j-BL] == 1) begin
                e_we[j] = 1;
                e_wa[j] = e_a[j-BL];
                e_wb[j] = e_b[j-BL];
            end
        end
    endtask

    // Run tracker and per-cycle compare.
    int mj = -1;
    bit rstf = 0, armed = 0;
    int busy_cnt = 0, done_cnt = 0;
    int cap_re[TOTAL], cap_a[TOTAL], cap_b[TOTAL], cap_tw[TOTAL];
    int cap_we[TOTAL], cap_wa[TOTAL], cap_wb[TOTAL];

    always begin
        @(posedge clk);
        if (!i_RST) begin
            mj = -1; rstf = 1; armed = 1;
        end else begin
            rstf = 0;
            if (mj >= 0)      mj = (mj == TOTAL - 1) ? -1 : mj + 1;
            else if (i_start) mj = 0;
        end
        @(negedge clk);
        if (armed) begin
            if (o_busy) busy_cnt++;
            if (o_done) done_cnt++;
            if (rstf) begin
                check("reset_outputs", 32'(|{o_busy, o_done, o_stage, o_read_en_A, o_read_en_B,
                      o_read_addr_A, o_read_addr_B, o_twiddle_addr, o_write_en_A, o_write_en_B,
                      o_write_addr_A, o_write_addr_B}), 0);
            end else if (mj < 0) begin
                check("idle_ctrl", 32'({o_read_en_A, o_read_en_B, o_write_en_A, o_write_en_B,
                      o_busy, o_done}), 0);
            end else begin
                int j;
                j = mj;
                cap_re[j] = int'(o_read_en_A); cap_a[j] = int'(o_read_addr_A);
                cap_b[j] = int'(o_read_addr_B); cap_tw[j] = int'(o_twiddle_addr);
                cap_we[j] = int'(o_write_en_A); cap_wa[j] = int'(o_write_addr_A);
                cap_wb[j] = int'(o_write_addr_B);
                check($sformatf("busy[%0d]", j), 32'(o_busy), (j < TOTAL - 1) ? 1 : 0);
                check($sformatf("done[%0d]", j), 32'(o_done), (j == TOTAL - 1) ? 1 : 0);
                check($sformatf("stage[%0d]", j), 32'(o_stage), e_st[j]);
                check($sformatf("read_en[%0d]", j), 32'({o_read_en_A, o_read_en_B}), e_re[j] * 3);
                if (e_re[j] == 1) begin
                    check($sformatf("rd_a[%0d]", j), 32'(o_read_addr_A), e_a[j]);
                    check($sformatf("rd_b[%0d]", j), 32'(o_read_addr_B), e_b[j]);
                    check($sformatf("tw[%0d]", j), 32'(o_twiddle_addr), e_tw[j]);
                end
                check($sformatf("write_en[%0d]", j), 32'({o_write_en_A, o_write_en_B}), e_we[j] * 3);
                if (e_we[j] == 1) begin
                    check($sformatf("wr_a[%0d]", j), 32'(o_write_addr_A), e_wa[j]);
                    check($sformatf("wr_b[%0d]", j), 32'(o_write_addr_B), e_wb[j]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    initial begin
        build_model();
        // Reset for two edges with i_start held high.
        i_RST = 1'b0;
        i_start = 1'b1;
        repeat (2) tick();
        i_RST = 1'b1;
        i_start = 1'b0;
        repeat (3) tick();
        check("idle_after_reset_busy", 32'(o_busy), 0);
        $display("txn reset: busy=%0b stage=%0d", o_busy, o_stage);

        // Run 1 with ignored starts at cycles 10 and 50.
        busy_cnt = 0; done_cnt = 0;
        pulse_start();
        repeat (9) tick();
        pulse_start();
        repeat (39) tick();
        pulse_start();
        repeat (50) tick();
        check("run1_busy_cycles", busy_cnt, 90);
        check("run1_done_pulses", done_cnt, 1);
        check("s0k0_a", cap_a[0], 0);   check("s0k0_b", cap_b[0], 1);   check("s0k0_tw", cap_tw[0], 0);
        check("s0k1_a", cap_a[1], 2);   check("s0k1_b", cap_b[1], 3);
        check("s0k15_a", cap_a[15], 30); check("s0k15_b", cap_b[15], 31);
        check("drain0_en", cap_re[16] + cap_re[17], 0);
        check("s1k0_en", cap_re[18], 1);
        check("s2k5_a", cap_a[41], 9);  check("s2k5_b", cap_b[41], 13); check("s2k5_tw", cap_tw[41], 4);
        check("s4k15_a", cap_a[87], 15); check("s4k15_b", cap_b[87], 31); check("s4k15_tw", cap_tw[87], 15);
        check("last_wr_en", cap_we[89], 1);
        check("last_wr_a", cap_wa[89], 15); check("last_wr_b", cap_wb[89], 31);
        $display("txn run1: busy=%0d done=%0d", busy_cnt, done_cnt);

        // Run 2: restart after DONE begins at s=0, k=0.
        busy_cnt = 0; done_cnt = 0;
        cap_a[0] = -1; cap_b[0] = -1;
        pulse_start();
        repeat (95) tick();
        check("run2_busy_cycles", busy_cnt, 90);
        check("run2_done_pulses", done_cnt, 1);
        check("run2_first_a", cap_a[0], 0);
        check("run2_first_b", cap_b[0], 1);
        $display("txn run2: busy=%0d done=%0d", busy_cnt, done_cnt);

        // Run 3: abort by reset during stage 2 READ.
        busy_cnt = 0; done_cnt = 0;
        pulse_start();
        repeat (39) tick();
        check("abort_in_stage2", 32'(o_stage), 2);
        i_RST = 1'b0;
        tick();
        i_RST = 1'b1;
        check("abort_busy", 32'(o_busy), 0);
        check("abort_stage", 32'(o_stage), 0);
        repeat (10) tick();
        check("abort_no_done", done_cnt, 0);
        $display("txn abort: busy_before=%0d done=%0d", busy_cnt, done_cnt);

        // Run 4: full transform after abort.
        busy_cnt = 0; done_cnt = 0;
        pulse_start();
        repeat (95) tick();
        check("run4_busy_cycles", busy_cnt, 90);
        check("run4_done_pulses", done_cnt, 1);
        $display("txn run4: busy=%0d done=%0d", busy_cnt, done_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
